// File: rtl/pack_leb128_pkg.sv
`default_nettype none
// ============================================================================
// pack_leb128_pkg
// Value-type tags shared with the CPU/stack and WebAssembly immediate lengths.
// Revision: 1.0
// ============================================================================
package pack_leb128_pkg;

  typedef enum logic [1:0] {
    VT_I32 = 2'b00,
    VT_I64 = 2'b01,
    VT_F32 = 2'b10,
    VT_F64 = 2'b11
  } val_type_t;

  localparam int unsigned MAX_LEN_I32 = 5;
  localparam int unsigned MAX_LEN_I64 = 10;
  localparam int unsigned MAX_LEN_F32 = 4;
  localparam int unsigned MAX_LEN_F64 = 8;

  // Index of the last permissible byte for a given value type.
  function automatic logic [3:0] max_index(input val_type_t t);
    case (t)
      VT_I32:  return 4'(MAX_LEN_I32 - 1);
      VT_I64:  return 4'(MAX_LEN_I64 - 1);
      VT_F32:  return 4'(MAX_LEN_F32 - 1);
      default: return 4'(MAX_LEN_F64 - 1);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pack_leb128_chunk.sv
`default_nettype none
// ============================================================================
// pack_leb128_chunk
// Combinational byte slicer: current output byte, last flag and shifted rest.
// Revision: 1.0
// ============================================================================
module pack_leb128_chunk
  import pack_leb128_pkg::*;
#(
  parameter bit PAD_EN = 1'b0
) (
  input  logic [63:0] sr,
  input  val_type_t   vtype,
  input  logic        at_max,
  output logic [7:0]  data,
  output logic        last,
  output logic [63:0] rest
);

  logic [6:0]  chunk;
  logic [63:0] sar7;
  logic        natural_last;

  assign chunk = sr[6:0];
  assign sar7  = $signed(sr) >>> 7;

  // Signed LEB128 terminates once the remaining bits are pure sign extension
  // of the chunk's top bit.
  assign natural_last = ((sar7 == 64'h0) && !chunk[6]) ||
                        ((sar7 == {64{1'b1}}) && chunk[6]);

  always_comb begin
    data = 8'h00;
    last = 1'b0;
    rest = 64'h0;
    case (vtype)
      VT_I32, VT_I64: begin
        rest = sar7;
        last = PAD_EN ? at_max : (natural_last || at_max);
        data = {~last, chunk};
      end
      default: begin
        rest = sr >> 8;
        last = at_max;
        data = sr[7:0];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pack_leb128.sv
`default_nettype none
// ============================================================================
// pack_leb128
// Streaming WebAssembly immediate encoder, one byte per clock, LSB first.
// Build option: PACK_LEB128_PAD_EN -> fixed-width (5/10 byte) integer form.
// Revision: 1.0
// ============================================================================
module pack_leb128
  import pack_leb128_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic [63:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [3:0]  out_index
);

`ifdef PACK_LEB128_PAD_EN
  localparam bit PAD_MODE = 1'b1;
`else
  localparam bit PAD_MODE = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] sr;
  val_type_t   vtype;
  logic [3:0]  cnt;

  logic        at_max;
  logic [7:0]  chunk_data;
  logic        chunk_last;
  logic [63:0] chunk_rest;
  logic        accept;
  logic        xfer;
  val_type_t   new_type;
  logic [63:0] new_sr;

  assign at_max = (cnt == max_index(vtype));

  pack_leb128_chunk #(
    .PAD_EN (PAD_MODE)
  ) u_chunk (
    .sr     (sr),
    .vtype  (vtype),
    .at_max (at_max),
    .data   (chunk_data),
    .last   (chunk_last),
    .rest   (chunk_rest)
  );

  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && chunk_last;
  assign out_index = out_valid ? cnt : 4'd0;
  assign out_data  = out_valid ? chunk_data : 8'h00;

  // Accepting during the final transfer keeps back-to-back values bubble-free.
  assign in_ready = (state == ST_IDLE) || (out_ready && out_last);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  assign new_type = val_type_t'(in_type);

  always_comb begin
    new_sr = in_value;
    case (new_type)
      VT_I32:  new_sr = {{32{in_value[31]}}, in_value[31:0]};
      VT_F32:  new_sr = {32'h0, in_value[31:0]};
      default: new_sr = in_value;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      sr    <= 64'h0;
      vtype <= VT_I32;
      cnt   <= 4'd0;
    end else if (accept) begin
      state <= ST_EMIT;
      sr    <= new_sr;
      vtype <= new_type;
      cnt   <= 4'd0;
    end else if (xfer) begin
      if (chunk_last) begin
        state <= ST_IDLE;
      end else begin
        sr  <= chunk_rest;
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pack_leb128.sv
`default_nettype none
// ============================================================================
// tb_pack_leb128
// Directed self-checking bench for the streaming LEB128/float immediate encoder.
// Revision: 1.0
// ============================================================================
module tb_pack_leb128;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [63:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_index;

  int total = 0;
  int bad   = 0;

  pack_leb128 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_index (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Present a value while the encoder is idle; it is taken at the next edge.
  task automatic offer(input string tag, input logic [1:0] t, input logic [63:0] v);
    @(negedge clk);
    in_valid  = 1'b1;
    in_type   = t;
    in_value  = v;
    out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Expected bytes packed with byte 0 in bits [7:0].
  task automatic expect_bytes(input string tag, input logic [79:0] exp, input int n,
                              input bit chain, input logic [1:0] nt,
                              input logic [63:0] nv, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          out_ready = 1'b0;
          in_valid  = 1'b0;
          #1;
          chk({tag, " stall valid"}, 64'(out_valid), 64'd1);
          chk({tag, " stall data"},  64'(out_data),  64'(exp[8*i +: 8]));
          chk({tag, " stall index"}, 64'(out_index), 64'(i));
        end
      end
      @(negedge clk);
      out_ready = 1'b1;
      if (chain && i == n - 1) begin
        in_valid = 1'b1;
        in_type  = nt;
        in_value = nv;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk({tag, " valid"}, 64'(out_valid), 64'd1);
      chk({tag, " data"},  64'(out_data),  64'(exp[8*i +: 8]));
      chk({tag, " last"},  64'(out_last),  64'(i == n - 1));
      chk({tag, " index"}, 64'(out_index), 64'(i));
      chk({tag, " ready"}, 64'(in_ready),  64'(i == n - 1));
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, " idle valid"}, 64'(out_valid), 64'd0);
    chk({tag, " idle ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_type   = 2'b00;
    in_value  = 64'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data",  64'(out_data),  64'd0);
    chk("rst out_last",  64'(out_last),  64'd0);
    chk("rst out_index", 64'(out_index), 64'd0);
    chk("rst in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b1;

`ifdef PACK_LEB128_PAD_EN
    offer("pad0", 2'b00, 64'h0);
    expect_bytes("pad0", 80'h0080808080, 5, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("pad0");
    offer("padm1", 2'b00, 64'h0000_0000_FFFF_FFFF);
    expect_bytes("padm1", 80'h7FFFFFFFFF, 5, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("padm1");
`else
    // i32 0 followed immediately by i32 -1
    offer("b2b0", 2'b00, 64'h0);
    expect_bytes("b2b0", 80'h00, 1, 1'b1, 2'b00, 64'hDEAD_BEEF_FFFF_FFFF, -1);
    expect_bytes("b2bm1", 80'h7F, 1, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("b2bm1");

    offer("i32_624485", 2'b00, 64'd624485);
    expect_bytes("i32_624485", 80'h268EE5, 3, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("i32_624485");

    offer("i32_64", 2'b00, 64'd64);
    expect_bytes("i32_64", 80'h00C0, 2, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("i32_64");

    offer("i64_min", 2'b01, 64'h8000_0000_0000_0000);
    expect_bytes("i64_min", 80'h7F808080808080808080, 10, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("i64_min");

    // Reset while byte 1 of i64 -129 (FF 7E) is pending
    offer("rstmid", 2'b01, 64'hFFFF_FFFF_FFFF_FF7F);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rstmid byte0", 64'(out_data), 64'hFF);
    chk("rstmid last0", 64'(out_last), 64'd0);
    @(negedge clk);
    #1;
    chk("rstmid byte1", 64'(out_data), 64'h7E);
    reset = 1'b0;
    #1;
    chk("rstmid valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid ready", 64'(in_ready), 64'd1);
    offer("i32_5", 2'b00, 64'd5);
    expect_bytes("i32_5", 80'h05, 1, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("i32_5");
`endif

    // Float payloads are identical in both builds; stall on byte 2.
    offer("f32", 2'b10, 64'hFFFF_FFFF_3F80_0000);
    expect_bytes("f32", 80'h3F800000, 4, 1'b0, 2'b00, 64'h0, 2);
    expect_idle("f32");

    offer("f64", 2'b11, 64'h0123_4567_89AB_CDEF);
    expect_bytes("f64", 80'h0123456789ABCDEF, 8, 1'b0, 2'b00, 64'h0, -1);
    expect_idle("f64");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
